tc_job_sched: RTL and testbench
===============================

TC_JOB_SCHED -- requirements
Module: tc_job_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of warp requesters sharing one tensor_core_exe.
REQ-002 Parameter KT_W, default 8, width of the per-job K-tile count.
REQ-003 Parameter OUT_BEATS, default 4, D-stream beats per job.
REQ-004 Parameter TO_CYCLES, default 1024, watchdog limit; used only with TC_SCHED_TIMEOUT_EN.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1, sole clock.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port req_valid_i, input, NUM_REQ, per-requester job request.
REQ-009 Port req_ready_o, output, NUM_REQ, one-hot job acceptance.
REQ-010 Port req_ktiles_i, input, NUM_REQ*KT_W, packed K-tile counts.
REQ-011 Port req_wid_i, input, NUM_REQ*`DEPTH_WARP, packed warp ids.
REQ-012 Port req_cfg_i, input, NUM_REQ*17, packed {layout[3:0], type_ab[4:0], type_ab_sub[2:0], type_cd[4:0]}.
REQ-013 Port en_o, output, 1, tensor-core enable.
REQ-014 Port cfg_o, output, 17, latched configuration of the active job.
REQ-015 Port wid_o, output, `DEPTH_WARP, warp id of the active job.
REQ-016 Ports a_hs_i, b_hs_i, c_hs_i, input, 1 each, input beat handshakes (tvalid&tready).
REQ-017 Ports tlast_a_o, tlast_b_o, tlast_c_o, output, 1 each, last-beat markers.
REQ-018 Port d_hs_i, input, 1, output-stream handshake (m_axis_tvalid_d&m_axis_tready_d).
REQ-019 Port abort_i, input, 1, abort the active job.
REQ-020 Port busy_o, output, 1, high in any state other than IDLE.
REQ-021 Port irq_en_i, input, 8, interrupt enable mask.
REQ-022 Port irq_clr_i, input, 8, write-1-to-clear for the sticky interrupt status.
REQ-023 Port irq_o, output, 8, sticky status AND irq_en_i.
REQ-024 Port done_wid_o, output, `DEPTH_WARP, warp id of the last completed or terminated job.

Function
REQ-025 States: IDLE, LOAD, DRAIN, DONE. One-hot or encoded is an implementation choice; behaviour is fixed as below.
REQ-026 IDLE, with any req_valid_i set: round-robin grant starting after the previous winner; req_ready_o high for exactly that cycle; latch ktiles, wid and cfg; go to LOAD.
REQ-027 A ktiles value of 0 SHALL be treated as 1.
REQ-028 LOAD: en_o=1. Independent A, B and C counters each advance on their own handshake. Each saturates at ktiles and ignores further beats.
REQ-029 tlast_x_o=1 while counter x equals ktiles-1. It is combinational, so it is valid in the cycle of the last handshake.
REQ-030 LOAD→DRAIN in the cycle after all three counters reach ktiles. A final beat arriving in that cycle is counted.
REQ-031 DRAIN: en_o=1. Count d_hs_i. On the OUT_BEATS-th beat go to DONE.
REQ-032 DONE lasts one cycle: set status bit 0 (job done), load done_wid_o, go to IDLE. Rotate the arbiter pointer to the winner.
REQ-033 abort_i in LOAD or DRAIN: go to IDLE next cycle, set status bit 1, load done_wid_o. abort_i is ignored in IDLE and DONE.
REQ-034 Sticky status: set has priority over irq_clr_i in the same cycle. Bits 7:3 SHALL always read 0.
REQ-035 Grants SHALL NOT be issued in any state other than IDLE; requests are held, not dropped.

Reset
REQ-036 On rst, all of the following SHALL be 0: state=IDLE, arbiter pointer, counters, status, en_o, busy_o, req_ready_o, tlast_*_o, cfg_o, wid_o, done_wid_o.
REQ-037 rst mid-job SHALL discard the job with no interrupt raised.

Configuration
REQ-038 Macro TC_SCHED_TIMEOUT_EN, when defined: in DRAIN, a counter is cleared on each d_hs_i. When it reaches TO_CYCLES, go to IDLE and set status bit 2.
REQ-039 Macro TC_SCHED_TIMEOUT_EN, when undefined: there is no watchdog logic, and status bit 2 reads 0.

Structure
REQ-040 A shared package SHALL hold the state enum, the 17-bit cfg field offsets, and the irq bit indices (DONE=0, ABORT=1, TIMEOUT=2).
REQ-041 The round-robin arbiter SHALL be the single sub-module tc_rr_arb (NUM_REQ parameter; inputs req, advance; output one-hot grant).

Verification
REQ-042 Single job: req_valid_i=0001, ktiles=3, 3 A/B/C beats, then 4 D beats → tlast_* on 3rd beat, DONE 1 cycle, irq_o[0]=1 with irq_en_i=01.
REQ-043 Fairness: req_valid_i=1111 held, jobs of ktiles=1 → grant order 0,1,2,3,0.
REQ-044 Skewed streams: A 3 beats early, C last, ktiles=3 → stays in LOAD until the 3rd C beat; extra A beat ignored.
REQ-045 abort_i in DRAIN after 2 D beats → IDLE next cycle, irq status bit 1=1, bit 0=0, done_wid_o=job wid.
REQ-046 irq_clr_i=01 coincident with a new DONE → bit 0 stays 1. ktiles=0 → tlast on the first beat.
REQ-047 With TC_SCHED_TIMEOUT_EN and TO_CYCLES=16: no D beats for 16 cycles → IDLE and status bit 2=1. Without the macro, the bench stays in DRAIN.

Source files
------------

// File: rtl/tc_job_sched_pkg.sv
// Shared types and constants for the tensor-core job scheduler.
// Holds the FSM state enum, the packed cfg field offsets and the irq status bit indices.
package tc_job_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

    // cfg word is {layout[3:0], type_ab[4:0], type_ab_sub[2:0], type_cd[4:0]}
    localparam int CFG_W               = 17;
    localparam int CFG_TYPE_CD_LSB     = 0;
    localparam int CFG_TYPE_AB_SUB_LSB = 5;
    localparam int CFG_TYPE_AB_LSB     = 8;
    localparam int CFG_LAYOUT_LSB      = 13;

    localparam int IRQ_DONE    = 0;
    localparam int IRQ_ABORT   = 1;
    localparam int IRQ_TIMEOUT = 2;

endpackage

// File: rtl/tc_rr_arb.sv
// Round-robin arbiter: priority starts at the requester after the last completed winner.
// The pointer only moves when 'advance' is pulsed, so aborted jobs do not lose their turn.
module tc_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] last_win;
    logic [PW-1:0] win_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            last_win <= '0;
        end else begin
            if (found)
                last_win <= win_idx;
            if (advance)
                ptr <= (last_win == PW'(NUM_REQ - 1)) ? '0 : last_win + PW'(1);
        end
    end

endmodule

// File: rtl/tc_job_sched.sv
// Job scheduler sharing one tensor_core_exe among NUM_REQ warp requesters.
// Optional watchdog in DRAIN is enabled by defining TC_SCHED_TIMEOUT_EN.
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif
module tc_job_sched
    import tc_job_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int KT_W      = 8,
    parameter int OUT_BEATS = 4,
    parameter int TO_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*KT_W-1:0]         req_ktiles_i,
    input  logic [NUM_REQ*`DEPTH_WARP-1:0]  req_wid_i,
    input  logic [NUM_REQ*CFG_W-1:0]        req_cfg_i,
    output logic                            en_o,
    output logic [CFG_W-1:0]                cfg_o,
    output logic [`DEPTH_WARP-1:0]          wid_o,
    input  logic                            a_hs_i,
    input  logic                            b_hs_i,
    input  logic                            c_hs_i,
    output logic                            tlast_a_o,
    output logic                            tlast_b_o,
    output logic                            tlast_c_o,
    input  logic                            d_hs_i,
    input  logic                            abort_i,
    output logic                            busy_o,
    input  logic [7:0]                      irq_en_i,
    input  logic [7:0]                      irq_clr_i,
    output logic [7:0]                      irq_o,
    output logic [`DEPTH_WARP-1:0]          done_wid_o
);

    localparam int DW     = `DEPTH_WARP;
    localparam int DCNT_W = (OUT_BEATS > 1) ? $clog2(OUT_BEATS + 1) : 1;

    sched_state_e       state;
    logic [KT_W-1:0]    ktiles, cnt_a, cnt_b, cnt_c;
    logic [KT_W-1:0]    nxt_a, nxt_b, nxt_c;
    logic [DCNT_W-1:0]  cnt_d;
    logic [NUM_REQ-1:0] grant;
    logic [KT_W-1:0]    sel_kt;
    logic [DW-1:0]      sel_wid;
    logic [CFG_W-1:0]   sel_cfg;
    logic [2:0]         status;
    logic [2:0]         status_set;
    logic               load_done, d_last, abort_hit, timeout_hit;
    logic               unused_irq_hi;

    tc_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid_i & {NUM_REQ{(state == ST_IDLE) && !rst}}),
        .advance (state == ST_DONE),
        .grant   (grant)
    );

    assign req_ready_o = grant;

    always_comb begin
        sel_kt  = '0;
        sel_wid = '0;
        sel_cfg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_kt  = sel_kt  | req_ktiles_i[i*KT_W +: KT_W];
                sel_wid = sel_wid | req_wid_i[i*DW +: DW];
                sel_cfg = sel_cfg | req_cfg_i[i*CFG_W +: CFG_W];
            end
        end
    end

    // Each operand counter saturates at ktiles so surplus beats are ignored.
    always_comb begin
        nxt_a     = (a_hs_i && cnt_a != ktiles) ? cnt_a + KT_W'(1) : cnt_a;
        nxt_b     = (b_hs_i && cnt_b != ktiles) ? cnt_b + KT_W'(1) : cnt_b;
        nxt_c     = (c_hs_i && cnt_c != ktiles) ? cnt_c + KT_W'(1) : cnt_c;
        load_done = (nxt_a == ktiles) && (nxt_b == ktiles) && (nxt_c == ktiles);
        d_last    = d_hs_i && (cnt_d == DCNT_W'(OUT_BEATS - 1));
        abort_hit = abort_i && ((state == ST_LOAD) || (state == ST_DRAIN));
    end

    assign tlast_a_o = (state == ST_LOAD) && (cnt_a == ktiles - KT_W'(1));
    assign tlast_b_o = (state == ST_LOAD) && (cnt_b == ktiles - KT_W'(1));
    assign tlast_c_o = (state == ST_LOAD) && (cnt_c == ktiles - KT_W'(1));

`ifdef TC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_DRAIN || d_hs_i)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout_hit = (state == ST_DRAIN) && !d_hs_i && (to_cnt == TO_W'(TO_CYCLES - 1));
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES == 0);
    assign timeout_hit      = 1'b0;
`endif

    always_comb begin
        status_set              = '0;
        status_set[IRQ_DONE]    = (state == ST_DONE);
        status_set[IRQ_ABORT]   = abort_hit;
        status_set[IRQ_TIMEOUT] = timeout_hit && !abort_hit;
    end

    assign irq_o         = {5'b0, status & irq_en_i[2:0]};
    assign unused_irq_hi = ^{irq_en_i[7:3], irq_clr_i[7:3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ktiles     <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            cnt_c      <= '0;
            cnt_d      <= '0;
            status     <= '0;
            en_o       <= 1'b0;
            busy_o     <= 1'b0;
            cfg_o      <= '0;
            wid_o      <= '0;
            done_wid_o <= '0;
        end else begin
            // A new set event wins over a same-cycle clear of that bit.
            status <= (status & ~irq_clr_i[2:0]) | status_set;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        ktiles <= (sel_kt == '0) ? KT_W'(1) : sel_kt;
                        wid_o  <= sel_wid;
                        cfg_o  <= sel_cfg;
                        cnt_a  <= '0;
                        cnt_b  <= '0;
                        cnt_c  <= '0;
                        cnt_d  <= '0;
                        en_o   <= 1'b1;
                        busy_o <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort_hit) begin
                        en_o       <= 1'b0;
                        busy_o     <= 1'b0;
                        done_wid_o <= wid_o;
                        state      <= ST_IDLE;
                    end else begin
                        cnt_a <= nxt_a;
                        cnt_b <= nxt_b;
                        cnt_c <= nxt_c;
                        if (load_done)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort_hit || timeout_hit) begin
                        en_o       <= 1'b0;
                        busy_o     <= 1'b0;
                        done_wid_o <= wid_o;
                        state      <= ST_IDLE;
                    end else if (d_last) begin
                        en_o  <= 1'b0;
                        state <= ST_DONE;
                    end else if (d_hs_i) begin
                        cnt_d <= cnt_d + DCNT_W'(1);
                    end
                end
                default: begin
                    busy_o     <= 1'b0;
                    done_wid_o <= wid_o;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_job_sched.sv
// Directed self-checking bench for tc_job_sched (NUM_REQ=4, KT_W=8, OUT_BEATS=4, TO_CYCLES=16).
// Define TC_SCHED_TIMEOUT_EN for both bench and RTL to exercise the watchdog expectations.
`ifndef DEPTH_WARP
`define DEPTH_WARP 5
`endif
module tb_tc_job_sched;
    import tc_job_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int KT_W    = 8;
    localparam int DW      = `DEPTH_WARP;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*KT_W-1:0]  req_ktiles;
    logic [NUM_REQ*DW-1:0]    req_wid;
    logic [NUM_REQ*CFG_W-1:0] req_cfg;
    logic                     en;
    logic [CFG_W-1:0]         cfg;
    logic [DW-1:0]            wid;
    logic                     a_hs, b_hs, c_hs, d_hs;
    logic                     tlast_a, tlast_b, tlast_c;
    logic                     abort;
    logic                     busy;
    logic [7:0]               irq_en, irq_clr, irq;
    logic [DW-1:0]            done_wid;

    int checks = 0;
    int passed = 0;

    tc_job_sched #(.NUM_REQ(NUM_REQ), .KT_W(KT_W), .OUT_BEATS(4), .TO_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_ktiles_i(req_ktiles), .req_wid_i(req_wid), .req_cfg_i(req_cfg),
        .en_o(en), .cfg_o(cfg), .wid_o(wid),
        .a_hs_i(a_hs), .b_hs_i(b_hs), .c_hs_i(c_hs),
        .tlast_a_o(tlast_a), .tlast_b_o(tlast_b), .tlast_c_o(tlast_c),
        .d_hs_i(d_hs), .abort_i(abort), .busy_o(busy),
        .irq_en_i(irq_en), .irq_clr_i(irq_clr), .irq_o(irq),
        .done_wid_o(done_wid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int idx, input logic [KT_W-1:0] kt, input logic [DW-1:0] w,
                           input logic [CFG_W-1:0] c);
        req_ktiles[idx*KT_W +: KT_W] = kt;
        req_wid[idx*DW +: DW]        = w;
        req_cfg[idx*CFG_W +: CFG_W]  = c;
    endtask

    task automatic clear_status();
        irq_clr = 8'hff;
        step();
        irq_clr = 8'h00;
    endtask

    // Walks a granted job from LOAD through all operand beats and OUT_BEATS D beats into DONE.
    task automatic run_ktile1_job();
        a_hs = 1; b_hs = 1; c_hs = 1;
        step();
        a_hs = 0; b_hs = 0; c_hs = 0;
        d_hs = 1;
        step(4);
        d_hs = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 4'b1111; irq_en = 8'hff;
        step(2);
        checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready); else passed++;
        checks++; if ({en, busy} !== 2'b00) $display("[TB] FAIL reset_en_busy: got %b expected 00", {en, busy}); else passed++;
        checks++; if ({tlast_a, tlast_b, tlast_c} !== 3'b000) $display("[TB] FAIL reset_tlast: got %b expected 000", {tlast_a, tlast_b, tlast_c}); else passed++;
        checks++; if ({cfg, wid, done_wid} !== '0) $display("[TB] FAIL reset_cfg_wid: got %h/%h/%h expected 0", cfg, wid, done_wid); else passed++;
        checks++; if (irq !== 8'h00) $display("[TB] FAIL reset_irq: got %h expected 00", irq); else passed++;
        req_valid = 4'b0000;
        rst = 0;
        step();
    endtask

    task automatic test_fairness();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'd1, DW'(k + 1), CFG_W'(k));
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (req_ready !== 4'(1 << exp_order[j]))
                $display("[TB] FAIL fair_grant%0d: got %b expected %b", j, req_ready, 4'(1 << exp_order[j]));
            else passed++;
            step();
            checks++;
            if (req_ready !== 4'b0000)
                $display("[TB] FAIL fair_hold%0d: got %b expected 0000", j, req_ready);
            else passed++;
            run_ktile1_job();
            step();
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_single_job();
        logic [CFG_W-1:0] c0;
        c0 = {4'h5, 5'h0a, 3'h3, 5'h11};
        clear_status();
        irq_en = 8'h01;
        set_req(0, 8'd3, 5'd7, c0);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        checks++; if ({en, busy} !== 2'b11) $display("[TB] FAIL single_load_en: got %b expected 11", {en, busy}); else passed++;
        checks++; if (wid !== 5'd7 || cfg !== c0) $display("[TB] FAIL single_latch: got %h/%h expected 07/%h", wid, cfg, c0); else passed++;
        a_hs = 1; b_hs = 1; c_hs = 1;
        #1;
        checks++; if ({tlast_a, tlast_b, tlast_c} !== 3'b000) $display("[TB] FAIL single_tlast_beat1: got %b expected 000", {tlast_a, tlast_b, tlast_c}); else passed++;
        step(2);
        checks++; if ({tlast_a, tlast_b, tlast_c} !== 3'b111) $display("[TB] FAIL single_tlast_beat3: got %b expected 111", {tlast_a, tlast_b, tlast_c}); else passed++;
        step();
        a_hs = 0; b_hs = 0; c_hs = 0;
        #1;
        checks++; if ({en, tlast_a} !== 2'b10) $display("[TB] FAIL single_drain: got %b expected 10", {en, tlast_a}); else passed++;
        d_hs = 1;
        step(4);
        d_hs = 0;
        checks++; if ({en, busy, irq[0]} !== 3'b010) $display("[TB] FAIL single_done_state: got %b expected 010", {en, busy, irq[0]}); else passed++;
        step();
        checks++; if ({busy, irq} !== {1'b0, 8'h01}) $display("[TB] FAIL single_irq: got %b/%h expected 0/01", busy, irq); else passed++;
        checks++; if (done_wid !== 5'd7) $display("[TB] FAIL single_done_wid: got %0d expected 7", done_wid); else passed++;
        irq_en = 8'hff;
    endtask

    task automatic test_skewed();
        clear_status();
        set_req(1, 8'd3, 5'd9, '0);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL skew_grant: got %b expected 0010", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        a_hs = 1;
        step(2);
        checks++; if (tlast_a !== 1'b1) $display("[TB] FAIL skew_tlast_a: got %b expected 1", tlast_a); else passed++;
        step(2);
        checks++; if (tlast_a !== 1'b0) $display("[TB] FAIL skew_a_saturate: got %b expected 0", tlast_a); else passed++;
        a_hs = 0; b_hs = 1;
        step(3);
        b_hs = 0; c_hs = 1; d_hs = 1;
        step(2);
        d_hs = 0;
        checks++; if ({tlast_c, en} !== 2'b11) $display("[TB] FAIL skew_last_c: got %b expected 11", {tlast_c, en}); else passed++;
        step();
        c_hs = 0; d_hs = 1;
        step(3);
        checks++; if ({en, busy} !== 2'b11) $display("[TB] FAIL skew_d_in_load_ignored: got %b expected 11", {en, busy}); else passed++;
        step();
        d_hs = 0;
        checks++; if ({en, busy} !== 2'b01) $display("[TB] FAIL skew_done: got %b expected 01", {en, busy}); else passed++;
        step();
        checks++; if (done_wid !== 5'd9) $display("[TB] FAIL skew_done_wid: got %0d expected 9", done_wid); else passed++;
    endtask

    task automatic test_abort();
        clear_status();
        set_req(2, 8'd1, 5'd21, '0);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        a_hs = 1; b_hs = 1; c_hs = 1;
        step();
        a_hs = 0; b_hs = 0; c_hs = 0; d_hs = 1;
        step(2);
        d_hs = 0; abort = 1;
        step();
        abort = 0;
        checks++; if ({en, busy} !== 2'b00) $display("[TB] FAIL abort_idle: got %b expected 00", {en, busy}); else passed++;
        checks++; if (irq !== 8'h02) $display("[TB] FAIL abort_irq: got %h expected 02", irq); else passed++;
        checks++; if (done_wid !== 5'd21) $display("[TB] FAIL abort_done_wid: got %0d expected 21", done_wid); else passed++;
        clear_status();
        abort = 1;
        step();
        abort = 0;
        checks++; if ({busy, irq} !== 9'h000) $display("[TB] FAIL abort_in_idle: got %b/%h expected 0/00", busy, irq); else passed++;
    endtask

    task automatic test_clr_priority_ktiles0();
        clear_status();
        set_req(3, 8'd0, 5'd3, '0);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) $display("[TB] FAIL kt0_grant: got %b expected 1000", req_ready); else passed++;
        step();
        req_valid = 4'b0000;
        a_hs = 1; b_hs = 1; c_hs = 1;
        #1;
        checks++; if ({tlast_a, tlast_b, tlast_c} !== 3'b111) $display("[TB] FAIL kt0_tlast_first: got %b expected 111", {tlast_a, tlast_b, tlast_c}); else passed++;
        step();
        a_hs = 0; b_hs = 0; c_hs = 0; d_hs = 1;
        step(4);
        d_hs = 0; irq_clr = 8'h01;
        step();
        irq_clr = 8'h00;
        checks++; if (irq !== 8'h01) $display("[TB] FAIL clr_vs_set: got %h expected 01", irq); else passed++;
        irq_clr = 8'h01;
        step();
        irq_clr = 8'h00;
        checks++; if (irq !== 8'h00) $display("[TB] FAIL clr_works: got %h expected 00", irq); else passed++;
    endtask

    task automatic test_timeout();
        clear_status();
        set_req(0, 8'd1, 5'd11, '0);
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        a_hs = 1; b_hs = 1; c_hs = 1;
        step();
        a_hs = 0; b_hs = 0; c_hs = 0;
        step(15);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL to_before_limit: got %b expected 1", busy); else passed++;
        step();
`ifdef TC_SCHED_TIMEOUT_EN
        checks++; if ({en, busy} !== 2'b00) $display("[TB] FAIL to_idle: got %b expected 00", {en, busy}); else passed++;
        checks++; if (irq !== 8'h04 || done_wid !== 5'd11) $display("[TB] FAIL to_irq: got %h/%0d expected 04/11", irq, done_wid); else passed++;
`else
        step(4);
        checks++; if ({en, busy} !== 2'b11) $display("[TB] FAIL to_stays_drain: got %b expected 11", {en, busy}); else passed++;
        checks++; if (irq !== 8'h00) $display("[TB] FAIL to_no_irq: got %h expected 00", irq); else passed++;
        abort = 1;
        step();
        abort = 0;
`endif
    endtask

    task automatic test_reset_mid_job();
        clear_status();
        set_req(1, 8'd2, 5'd13, '1);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        a_hs = 1;
        step();
        a_hs = 0; rst = 1;
        step();
        rst = 0;
        checks++; if ({en, busy, irq} !== 10'h000) $display("[TB] FAIL rst_mid_job: got %b/%b/%h expected 0/0/00", en, busy, irq); else passed++;
        checks++; if ({wid, cfg} !== '0) $display("[TB] FAIL rst_mid_job_latch: got %h/%h expected 0", wid, cfg); else passed++;
    endtask

    initial begin
        rst = 1; req_valid = '0; req_ktiles = '0; req_wid = '0; req_cfg = '0;
        a_hs = 0; b_hs = 0; c_hs = 0; d_hs = 0; abort = 0;
        irq_en = 8'hff; irq_clr = 8'h00;
        test_reset();
        test_fairness();
        test_single_job();
        test_skewed();
        test_abort();
        test_clr_priority_ktiles0();
        test_timeout();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
